// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter that merges N_PORTS AXI-Stream slaves
// into one master stream. The output passes through a registered 2-entry skid
// stage so that no slave ready depends combinationally on m_tready.
//
// Handshake semantics (both sides): a beat transfers on a rising clk edge where
// valid & ready are both high. valid never waits for ready, and once valid is
// high the payload stays stable and valid stays high until that transfer.
module axis_packet_arbiter #(
  parameter int N_PORTS     = 4,
  parameter int AXIS_DWIDTH = 32,
  parameter int CFG_DWIDTH  = 8,
  localparam int IDW        = $clog2(N_PORTS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_PORTS-1:0]             port_enable,
  output logic [CFG_DWIDTH-1:0]          count_pkts,
  input  logic                           count_clear,
  input  logic [N_PORTS*AXIS_DWIDTH-1:0] s_tdata,
  input  logic [N_PORTS-1:0]             s_tlast,
  input  logic [N_PORTS-1:0]             s_tvalid,
  output logic [N_PORTS-1:0]             s_tready,
  output logic [AXIS_DWIDTH-1:0]         m_tdata,
  output logic                           m_tlast,
  output logic [IDW-1:0]                 m_tid,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic                           dbg_state
);

  typedef enum logic {IDLE = 1'b0, PASS = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [IDW-1:0]         grant_q, grant_d;
  logic [IDW-1:0]         last_grant_q, last_grant_d;
  logic [N_PORTS-1:0]     req;
  logic                   found;
  logic [IDW-1:0]         cand;

  // Skid stage: head entry drives the master outputs, tail holds the overflow.
  logic [AXIS_DWIDTH-1:0] head_data_q, tail_data_q;
  logic                   head_last_q, tail_last_q;
  logic [IDW-1:0]         head_tid_q, tail_tid_q;
  logic [1:0]             occ_q;
  logic                   stage_full;
  logic                   push, pop;
  logic [AXIS_DWIDTH-1:0] in_data;
  logic                   in_last;

  assign req        = s_tvalid & port_enable;
  assign stage_full = (occ_q == 2'd2);
  assign in_data    = s_tdata[int'(grant_q)*AXIS_DWIDTH +: AXIS_DWIDTH];
  assign in_last    = s_tlast[grant_q];
  assign pop        = (occ_q != 2'd0) & m_tready;

  assign m_tvalid   = (occ_q != 2'd0);
  assign m_tlast    = head_last_q & m_tvalid;
  assign m_tdata    = head_data_q;
  assign m_tid      = head_tid_q;
  assign dbg_state  = (state_q == PASS);

  // Arbitration FSM state, current grant and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDW'(N_PORTS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state: pick the next requester after last_grant in IDLE, stream the
  // granted port in PASS until its tlast beat is accepted.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    s_tready     = '0;
    push         = 1'b0;
    found        = 1'b0;
    cand         = '0;
    case (state_q)
      IDLE: begin
        for (int k = 1; k <= N_PORTS; k++) begin
          cand = IDW'((int'(last_grant_q) + k) % N_PORTS);
          if (!found && req[cand]) begin
            found        = 1'b1;
            grant_d      = cand;
            last_grant_d = cand;
          end
        end
        if (found) state_d = PASS;
      end
      PASS: begin
        s_tready[grant_q] = ~stage_full;
        push              = s_tvalid[grant_q] & ~stage_full;
        if (push && in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Skid stage storage; a push never coincides with a full stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q       <= 2'd0;
      head_data_q <= '0;
      head_last_q <= 1'b0;
      head_tid_q  <= '0;
      tail_data_q <= '0;
      tail_last_q <= 1'b0;
      tail_tid_q  <= '0;
    end else begin
      case (occ_q)
        2'd0: begin
          if (push) begin
            head_data_q <= in_data;
            head_last_q <= in_last;
            head_tid_q  <= grant_q;
            occ_q       <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_data_q <= in_data;
            head_last_q <= in_last;
            head_tid_q  <= grant_q;
          end else if (push) begin
            tail_data_q <= in_data;
            tail_last_q <= in_last;
            tail_tid_q  <= grant_q;
            occ_q       <= 2'd2;
          end else if (pop) begin
            occ_q <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_data_q <= tail_data_q;
            head_last_q <= tail_last_q;
            head_tid_q  <= tail_tid_q;
            occ_q       <= 2'd1;
          end
        end
        default: occ_q <= 2'd0;
      endcase
    end
  end

  // Packet counter: clear wins over a same-cycle tlast transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_pkts <= '0;
    end else if (count_clear) begin
      count_pkts <= '0;
    end else if (pop && head_last_q) begin
      count_pkts <= count_pkts + 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Bench for axis_packet_arbiter: directed packet scenarios, a packet-level
// round-robin model producing the expected merged stream, and one per-cycle
// compare step that checks every meaningful output against that model.
module tb_axis_packet_arbiter;

  localparam int NP  = 4;
  localparam int DW  = 32;
  localparam int CW  = 8;
  localparam int IDW = 2;
  localparam int EW  = IDW + 1 + DW;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NP-1:0]    port_enable = '1;
  logic [CW-1:0]    count_pkts;
  logic             count_clear = 1'b0;
  logic [NP*DW-1:0] s_tdata = '0;
  logic [NP-1:0]    s_tlast = '0;
  logic [NP-1:0]    s_tvalid = '0;
  logic [NP-1:0]    s_tready;
  logic [DW-1:0]    m_tdata;
  logic             m_tlast;
  logic [IDW-1:0]   m_tid;
  logic             m_tvalid;
  logic             m_tready = 1'b0;
  logic             dbg_state;

  always #5 clk = ~clk;

  axis_packet_arbiter #(.N_PORTS(NP), .AXIS_DWIDTH(DW), .CFG_DWIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .port_enable(port_enable),
    .count_pkts(count_pkts), .count_clear(count_clear),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tid(m_tid), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .dbg_state(dbg_state)
  );

  // ---------------- bench state ----------------
  logic [DW:0]    src_q[NP][$];     // per-port beats {last, data}
  logic [EW-1:0]  exp_q[$];         // expected master beats {tid, last, data}
  logic [NP-1:0]  mask_sched[$];    // port_enable in force at each arbitration
  int             tid_log[$];       // tid of each packet completed on master side
  int             beat_cyc[$];      // cycle index of each master transfer
  int             n_checks = 0;
  int             n_errors = 0;
  int             cyc = 0;
  int             occ = 0;
  int             stall_full = 0;
  int             mready_mode = 0;
  int             pat_i = 0;
  logic [CW-1:0]  exp_cnt = '0;
  logic [NP-1:0]  shs_prev = '0;
  logic           mhs_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model: packet-level round robin ----------------
  task automatic build_expected();
    logic [DW:0]    mq[NP][$];
    logic [DW:0]    b;
    logic [NP-1:0]  mask;
    logic [IDW-1:0] gt;
    int             last_g, ai, g, c;
    for (int p = 0; p < NP; p++) mq[p] = src_q[p];
    last_g = NP - 1;
    ai = 0;
    forever begin
      mask = mask_sched[(ai < mask_sched.size()) ? ai : mask_sched.size() - 1];
      g = -1;
      for (int k = 1; k <= NP; k++) begin
        c = (last_g + k) % NP;
        if (g < 0 && mask[c] && mq[c].size() > 0) g = c;
      end
      if (g < 0) break;
      gt = g[IDW-1:0];
      do begin
        b = mq[g].pop_front();
        exp_q.push_back({gt, b});
      end while (!b[DW] && mq[g].size() > 0);
      last_g = g;
      ai++;
    end
  endtask

  task automatic add_pkt(input int p, input logic [DW-1:0] base, input int len);
    for (int i = 0; i < len; i++) src_q[p].push_back({(i == len - 1), base + DW'(i)});
  endtask

  // ---------------- driver + compare, one clock cycle ----------------
  task automatic step();
    logic [EW-1:0] e;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) src_q[p].delete();
      exp_q.delete();
      s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b0;
      shs_prev = '0; mhs_prev = 1'b0; occ = 0; exp_cnt = '0;
      return;
    end
    // account for the transfers that happened on the edge just passed
    for (int p = 0; p < NP; p++)
      if (shs_prev[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
    occ = occ + int'(|shs_prev) - int'(mhs_prev);
    e = '0;
    if (mhs_prev && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e[DW]) tid_log.push_back(int'(e[EW-1 -: IDW]));
    end
    if (count_clear) exp_cnt = '0;
    else if (mhs_prev && e[DW]) exp_cnt = exp_cnt + 1'b1;
    // drive sources and downstream ready
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() > 0) begin
        s_tvalid[p] = 1'b1;
        s_tlast[p]  = src_q[p][0][DW];
        s_tdata[p*DW +: DW] = src_q[p][0][DW-1:0];
      end else begin
        s_tvalid[p] = 1'b0;
        s_tlast[p]  = 1'b0;
        s_tdata[p*DW +: DW] = '0;
      end
    end
    if (mready_mode == 0) m_tready = 1'b1;
    else m_tready = (pat_i % 4 == 0) || (pat_i % 4 == 3);
    pat_i++;
    #1;
    chk("ready_onehot", ($countones(s_tready) <= 1), 1);
    chk("tvalid_vs_fill", m_tvalid, (occ != 0));
    if (occ == 2) begin
      chk("ready_when_full", s_tready, 0);
      if (s_tvalid[0]) stall_full++;
    end
    if (m_tvalid) begin
      if (exp_q.size() == 0) chk("unexpected_beat", {m_tid, m_tlast, m_tdata}, 0);
      else chk("beat", {m_tid, m_tlast, m_tdata}, exp_q[0]);
    end else begin
      chk("tlast_without_valid", m_tlast, 0);
    end
    chk("count_pkts", count_pkts, exp_cnt);
    mhs_prev = m_tvalid & m_tready;
    shs_prev = s_tvalid & s_tready;
    if (mhs_prev) beat_cyc.push_back(cyc);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b1;
    tid_log.delete();
    beat_cyc.delete();
    mask_sched.delete();
    stall_full = 0;
    mready_mode = 0;
    pat_i = 0;
  endtask

  task automatic drain(input int max_cyc, input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < max_cyc) begin
      step();
      n++;
    end
    chk(name, exp_q.size(), 0);
    repeat (4) step();
  endtask

  // ---------------- scenarios ----------------
  int exp_rr[8];
  int exp_mask[5];
  int n;

  initial begin
    exp_rr   = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp_mask = '{0, 1, 3, 1, 3};

    // reset state
    #2;
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_count", count_pkts, 0);
    chk("rst_fsm_idle", dbg_state, 0);
    chk("rst_m_tdata", m_tdata, 0);
    apply_reset();

    // single port, latency and back-to-back beats
    port_enable = 4'b1111;
    mask_sched.push_back(4'b1111);
    add_pkt(2, 32'hA0, 4);
    build_expected();
    step();
    chk("lat_edge0", m_tvalid, 0);
    step();
    chk("lat_edge1", m_tvalid, 0);
    step();
    chk("lat_edge2_valid", m_tvalid, 1);
    chk("lat_edge2_data", m_tdata, 32'hA0);
    drain(20, "single_drain");
    chk("single_beats", beat_cyc.size(), 4);
    if (beat_cyc.size() == 4) chk("single_consecutive", beat_cyc[3] - beat_cyc[0], 3);
    chk("single_tid", (tid_log.size() > 0) ? tid_log[0] : -1, 2);
    chk("single_count", count_pkts, 1);

    // round robin with all ports busy
    apply_reset();
    port_enable = 4'b1111;
    mask_sched.push_back(4'b1111);
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < NP; p++) add_pkt(p, 32'h1000 * (p + 1) + 32'h10 * k, 2);
    build_expected();
    drain(100, "rr_drain");
    chk("rr_pkts", tid_log.size(), 8);
    for (int i = 0; i < 8 && i < tid_log.size(); i++)
      chk($sformatf("rr_order%0d", i), tid_log[i], exp_rr[i]);
    chk("rr_count", count_pkts, 8);

    // backpressure: m_tready 1,0,0,1,...
    apply_reset();
    port_enable = 4'b1111;
    mask_sched.push_back(4'b1111);
    mready_mode = 1;
    add_pkt(0, 32'hB0, 6);
    build_expected();
    drain(60, "bp_drain");
    chk("bp_beats", beat_cyc.size(), 6);
    chk("bp_full_stall_seen", (stall_full > 0), 1);
    chk("bp_count", count_pkts, 1);

    // mask: port 2 never eligible, port 0 dropped mid-packet
    apply_reset();
    port_enable = 4'b1011;
    mask_sched.push_back(4'b1011);
    mask_sched.push_back(4'b1010);
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < NP; p++) add_pkt(p, 32'h2000 * (p + 1) + 32'h10 * k, 4);
    build_expected();
    n = 0;
    do begin
      step();
      n++;
    end while (!s_tready[0] && n < 10);
    chk("mask_port0_granted", s_tready[0], 1);
    port_enable = 4'b1010;
    drain(100, "mask_drain");
    chk("mask_pkts", tid_log.size(), 5);
    for (int i = 0; i < 5 && i < tid_log.size(); i++)
      chk($sformatf("mask_order%0d", i), tid_log[i], exp_mask[i]);

    // counter wrap and clear priority
    apply_reset();
    port_enable = 4'b1111;
    mask_sched.push_back(4'b1111);
    for (int i = 0; i < 255; i++) add_pkt(1, DW'(i), 1);
    build_expected();
    drain(1500, "cnt_drain255");
    chk("cnt_255", count_pkts, 255);
    add_pkt(1, 32'h55, 1);
    build_expected();
    drain(20, "cnt_drain256");
    chk("cnt_wrap", count_pkts, 0);
    add_pkt(1, 32'h56, 1);
    build_expected();
    drain(20, "cnt_drain257");
    chk("cnt_after_wrap", count_pkts, 1);
    add_pkt(1, 32'h57, 1);
    build_expected();
    n = 0;
    while (!m_tvalid && n < 10) begin
      step();
      n++;
    end
    chk("clr_beat_ready", m_tvalid & m_tready & m_tlast, 1);
    count_clear = 1'b1;
    step();
    count_clear = 1'b0;
    chk("clr_priority", count_pkts, 0);
    drain(20, "clr_drain");

    // asynchronous reset in the middle of a packet
    apply_reset();
    port_enable = 4'b1111;
    mask_sched.push_back(4'b1111);
    add_pkt(0, 32'hC0, 8);
    add_pkt(1, 32'hD0, 1);
    build_expected();
    n = 0;
    while (exp_q.size() > 5 && n < 30) begin
      step();
      n++;
    end
    chk("areset_midpkt_busy", m_tvalid & s_tready[0], 1);
    #6;
    rst_n = 1'b0;
    #1;
    chk("areset_m_tvalid", m_tvalid, 0);
    chk("areset_s_tready", s_tready, 0);
    step();
    step();
    #2;
    rst_n = 1'b1;
    tid_log.delete();
    mask_sched.delete();
    mask_sched.push_back(4'b1111);
    add_pkt(0, 32'hE0, 1);
    add_pkt(1, 32'hE1, 1);
    build_expected();
    drain(20, "areset_drain");
    chk("areset_first_grant", (tid_log.size() > 0) ? tid_log[0] : -1, 0);
    chk("areset_count", count_pkts, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // bound on total run time
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

endmodule
